lsu_core: RTL and testbench
===========================

// Module: lsu_core
// PURPOSE
//  Load/store unit of the single-cycle RV32I core: byte-addressable data memory plus memory-mapped IO.
//  - IO: red/green LEDs, eight 7-segment displays, LCD, switches.
//  - Sits between the execute stage and the writeback mux.
//  - Writes commit on the clock edge; reads are combinational, so load data is valid in the issuing cycle.
// PARAMETERS
//  DMEM_WORDS  2048  data-memory depth in 32-bit words (8 KiB); index = i_lsu_addr[12:2]
// PORTS
//  i_clk           in   1      single clock, all state updates on rising edge
//  i_reset         in   1      synchronous, active-high reset
//  i_lsu_addr      in   32     byte address
//  i_st_data       in   32     store data, right-aligned (byte in [7:0], half in [15:0])
//  i_lsu_size      in   2      00=byte, 01=half, 10=word, 11=word
//  i_lsu_wren      in   1      1=store this cycle, 0=load
//  o_ld_data       out  32     load result, extended to 32 bits
//  o_io_ledr       out  32     red LED register
//  o_io_ledg       out  32     green LED register
//  o_io_hex[0:7]   out  7 ea   seven-segment patterns HEX0..HEX7, unpacked array
//  o_io_lcd        out  32     LCD control/data register
//  i_io_sw         in   32     switch inputs, read-only
// BEHAVIOUR
//  Memory map (full 32-bit decode; "base" = the exact address of the 32-bit word):
//  - DMEM  0x0000_0000..0x0000_1FFF  read/write
//  - LEDR  base 0x1000_0000  R/W
//  - LEDG  base 0x1000_1000  R/W
//  - HEX0-3  base 0x1000_2000  R/W; byte k bits [6:0] -> o_io_hex[k]
//  - HEX4-7  base 0x1000_3000  R/W; byte k bits [6:0] -> o_io_hex[4+k]
//  - LCD   base 0x1000_4000  R/W
//  - SW    base 0x1001_0000  read-only, returns i_io_sw
//  - Anything else is unmapped.
//  Lane selection:
//  - Word: addr[1:0] ignored (aligned down).
//  - Half: lane = addr[1] (0 -> bits 15:0, 1 -> bits 31:16); addr[0] ignored.
//  - Byte: lane = addr[1:0].
//  Stores (i_lsu_wren=1, i_reset=0):
//  - Selected lanes of the target word are written at the rising edge; other lanes are unchanged.
//  - Same byte-enable rules apply to DMEM and every R/W IO register.
//  - Stores to SW or unmapped addresses are ignored.
//  Loads:
//  - o_ld_data is combinational from i_lsu_addr, i_lsu_size and current state.
//  - The lane is shifted to bit 0 and extended.
//  - Unmapped addresses read 0.
//  - HEX registers read back their full stored 8-bit bytes.
//  - Load data is also driven while i_lsu_wren=1; it shows pre-store contents.
//  Read-after-write:
//  - A load in the cycle after a store sees the new data.
//  - A load in the same cycle sees the old data.
//  Reset (synchronous):
//  - ledr, ledg, lcd and all HEX bytes clear to 0 at the first edge with i_reset=1.
//  - DMEM is not cleared; its contents are undefined until written.
//  - Stores presented while i_reset=1 are discarded.
//  Outputs:
//  - o_io_* follow their registers directly; a register update is visible the cycle after the store edge.
// CONFIGURATION
//  LSU_UNSIGNED_EN defined:
//  - Adds input port i_lsu_unsigned (1 bit).
//  - Byte/half loads zero-extend when it is 1 and sign-extend when it is 0.
//  LSU_UNSIGNED_EN undefined:
//  - The port is absent; byte/half loads always sign-extend.
//  - The core implements LBU/LHU externally.
//  Word loads are unaffected in both builds.
// TESTING
//  1. Hold reset 1 cycle, then release.
//     - Required: LEDR=LEDG=LCD=0 and every o_io_hex=0.
//  2. Store words at addr 0,4,..,36 (sz=10) with ten distinct random values, then word-load each address.
//     - Required: each returns exactly the value stored; load of addr 0 returns the first value.
//  3. Store word 0x1122_3344 @0x40, then byte 0xAA @0x41 and half 0xBEEF @0x42.
//     - Required: word load @0x40 = 0xBEEF_AA44.
//     - Required: byte load @0x41 = 0xFFFF_FFAA (or 0x0000_00AA with unsigned=1).
//     - Required: half load @0x42 = 0xFFFF_BEEF.
//  4. Store word 0x1234_5678 @0x1000_0000 and 0x0000_00FF @0x1000_1000.
//     - Required: o_io_ledr=0x1234_5678 and o_io_ledg=0xFF one cycle later; loads read back the same values.
//  5. Store word 0x7F06_5B4F @0x1000_2000.
//     - Required: hex[0]=0x4F, hex[1]=0x5B, hex[2]=0x06, hex[3]=0x7F; hex[4..7] unchanged.
//  6. Switches and unmapped addresses, with i_io_sw=0xDEAD_BEEF:
//     - Word load @0x1001_0000 = 0xDEAD_BEEF.
//     - A store there changes nothing.
//     - Load @0x2000_0000 = 0.

Source files
------------

// File: rtl/lsu_core.sv
// lsu_core: load/store unit for the single-cycle RV32I core.
// Byte-addressable data memory plus memory-mapped LEDs, 7-segment, LCD and switches.
// Stores commit on the rising edge; loads are combinational.
// Optional feature macro: LSU_UNSIGNED_EN adds i_lsu_unsigned (zero-extending byte/half loads).
module lsu_core #(
    parameter int DMEM_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_lsu_size,
    input  logic        i_lsu_wren,
`ifdef LSU_UNSIGNED_EN
    input  logic        i_lsu_unsigned,
`endif
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex [0:7],
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [31:0] ADDR_LEDR  = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEDG  = 32'h1000_1000;
    localparam logic [31:0] ADDR_HEXLO = 32'h1000_2000;
    localparam logic [31:0] ADDR_HEXHI = 32'h1000_3000;
    localparam logic [31:0] ADDR_LCD   = 32'h1000_4000;
    localparam logic [31:0] ADDR_SW    = 32'h1001_0000;

    logic [31:0] r_dmem [0:DMEM_WORDS-1];
    logic [31:0] r_ledr;
    logic [31:0] r_ledg;
    logic [31:0] r_hex_lo;
    logic [31:0] r_hex_hi;
    logic [31:0] r_lcd;

    logic [31:0]   w_word_addr;
    logic [AW-1:0] w_dmem_idx;
    logic          w_sel_dmem;
    logic          w_sel_ledr;
    logic          w_sel_ledg;
    logic          w_sel_hexlo;
    logic          w_sel_hexhi;
    logic          w_sel_lcd;
    logic          w_sel_sw;
    logic [3:0]    w_be;
    logic [31:0]   w_st_lanes;
    logic [31:0]   w_rd_word;
    logic [7:0]    w_rd_byte;
    logic [15:0]   w_rd_half;
    logic          w_zext;
    logic          w_wr_en;

    // Full 32-bit address decode; register bases are exact word addresses
    assign w_word_addr = {i_lsu_addr[31:2], 2'b00};
    assign w_dmem_idx  = i_lsu_addr[AW+1:2];
    assign w_sel_dmem  = (i_lsu_addr[31:AW+2] == '0);
    assign w_sel_ledr  = (w_word_addr == ADDR_LEDR);
    assign w_sel_ledg  = (w_word_addr == ADDR_LEDG);
    assign w_sel_hexlo = (w_word_addr == ADDR_HEXLO);
    assign w_sel_hexhi = (w_word_addr == ADDR_HEXHI);
    assign w_sel_lcd   = (w_word_addr == ADDR_LCD);
    assign w_sel_sw    = (w_word_addr == ADDR_SW);

    assign w_wr_en = i_lsu_wren & ~i_reset;

`ifdef LSU_UNSIGNED_EN
    assign w_zext = i_lsu_unsigned;
`else
    assign w_zext = 1'b0;
`endif

    // Byte enables and lane-replicated store data from access size and low address bits
    always_comb begin
        w_be       = 4'b1111;
        w_st_lanes = i_st_data;
        case (i_lsu_size)
            2'b00: begin
                w_be       = 4'b0001 << i_lsu_addr[1:0];
                w_st_lanes = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                w_be       = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                w_st_lanes = {2{i_st_data[15:0]}};
            end
            default: begin
                w_be       = 4'b1111;
                w_st_lanes = i_st_data;
            end
        endcase
    end

    // Data memory: byte-lane writes, never reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en && w_sel_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_dmem[w_dmem_idx][8*b +: 8] <= w_st_lanes[8*b +: 8];
                end
            end
        end
    end

    // IO registers: synchronous clear, byte-lane writes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ledr   <= '0;
            r_ledg   <= '0;
            r_hex_lo <= '0;
            r_hex_hi <= '0;
            r_lcd    <= '0;
        end else if (i_lsu_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    if (w_sel_ledr)  r_ledr[8*b +: 8]   <= w_st_lanes[8*b +: 8];
                    if (w_sel_ledg)  r_ledg[8*b +: 8]   <= w_st_lanes[8*b +: 8];
                    if (w_sel_hexlo) r_hex_lo[8*b +: 8] <= w_st_lanes[8*b +: 8];
                    if (w_sel_hexhi) r_hex_hi[8*b +: 8] <= w_st_lanes[8*b +: 8];
                    if (w_sel_lcd)   r_lcd[8*b +: 8]    <= w_st_lanes[8*b +: 8];
                end
            end
        end
    end

    // Read word mux; unmapped addresses return zero
    always_comb begin
        w_rd_word = '0;
        if (w_sel_dmem)       w_rd_word = r_dmem[w_dmem_idx];
        else if (w_sel_ledr)  w_rd_word = r_ledr;
        else if (w_sel_ledg)  w_rd_word = r_ledg;
        else if (w_sel_hexlo) w_rd_word = r_hex_lo;
        else if (w_sel_hexhi) w_rd_word = r_hex_hi;
        else if (w_sel_lcd)   w_rd_word = r_lcd;
        else if (w_sel_sw)    w_rd_word = i_io_sw;
    end

    assign w_rd_byte = w_rd_word[8*i_lsu_addr[1:0] +: 8];
    assign w_rd_half = w_rd_word[16*i_lsu_addr[1] +: 16];

    // Shift the selected lane to bit 0 and extend
    always_comb begin
        case (i_lsu_size)
            2'b00:   o_ld_data = {{24{~w_zext & w_rd_byte[7]}}, w_rd_byte};
            2'b01:   o_ld_data = {{16{~w_zext & w_rd_half[15]}}, w_rd_half};
            default: o_ld_data = w_rd_word;
        endcase
    end

    assign o_io_ledr = r_ledr;
    assign o_io_ledg = r_ledg;
    assign o_io_lcd  = r_lcd;

    // Segment outputs take bits [6:0] of each stored HEX byte
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_hex
            assign o_io_hex[k]   = r_hex_lo[8*k +: 7];
            assign o_io_hex[k+4] = r_hex_hi[8*k +: 7];
        end
    endgenerate

endmodule

// File: tb/tb_lsu_core.sv
// Self-checking bench for lsu_core: directed scenarios plus randomized
// load/store traffic against a byte-addressed reference model.
module tb_lsu_core;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic [1:0]  i_lsu_size;
    logic        i_lsu_wren;
    logic        i_lsu_unsigned;
    logic [31:0] o_ld_data;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [6:0]  o_io_hex [0:7];
    logic [31:0] o_io_lcd;
    logic [31:0] i_io_sw;

`ifdef LSU_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    lsu_core dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_lsu_addr     (i_lsu_addr),
        .i_st_data      (i_st_data),
        .i_lsu_size     (i_lsu_size),
        .i_lsu_wren     (i_lsu_wren),
`ifdef LSU_UNSIGNED_EN
        .i_lsu_unsigned (i_lsu_unsigned),
`endif
        .o_ld_data      (o_ld_data),
        .o_io_ledr      (o_io_ledr),
        .o_io_ledg      (o_io_ledg),
        .o_io_hex       (o_io_hex),
        .o_io_lcd       (o_io_lcd),
        .i_io_sw        (i_io_sw)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  m_dmem [0:8191];
    bit          m_vld  [0:8191];
    logic [31:0] m_ledr, m_ledg, m_lcd;
    logic [7:0]  m_hex [0:7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a, output bit known);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        known = 1'b1;
        if (a < 32'h2000) begin
            known = m_vld[wa] && m_vld[wa+1] && m_vld[wa+2] && m_vld[wa+3];
            return {m_dmem[wa+3], m_dmem[wa+2], m_dmem[wa+1], m_dmem[wa]};
        end
        case (wa)
            32'h1000_0000: return m_ledr;
            32'h1000_1000: return m_ledg;
            32'h1000_2000: return {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
            32'h1000_3000: return {m_hex[7], m_hex[6], m_hex[5], m_hex[4]};
            32'h1000_4000: return m_lcd;
            32'h1001_0000: return i_io_sw;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                           input bit us, output bit known);
        logic [31:0] w, r;
        w = m_word(a, known);
        if (sz == 2'b00) begin
            r = (w >> (8 * a[1:0])) & 32'hFF;
            if (!(us && UNS_EN) && r[7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            r = (w >> (16 * a[1])) & 32'hFFFF;
            if (!(us && UNS_EN) && r[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = w;
        end
        return r;
    endfunction

    task automatic m_put(input logic [31:0] wa, input int l, input logic [7:0] b);
        if (wa < 32'h2000) begin
            m_dmem[wa + l] = b;
            m_vld[wa + l]  = 1'b1;
        end else if (wa == 32'h1000_0000) m_ledr[8*l +: 8] = b;
        else if (wa == 32'h1000_1000) m_ledg[8*l +: 8] = b;
        else if (wa == 32'h1000_2000) m_hex[l] = b;
        else if (wa == 32'h1000_3000) m_hex[4+l] = b;
        else if (wa == 32'h1000_4000) m_lcd[8*l +: 8] = b;
    endtask

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (sz == 2'b00) begin
            m_put(wa, int'(a[1:0]), d[7:0]);
        end else if (sz == 2'b01) begin
            m_put(wa, 2 * int'(a[1]), d[7:0]);
            m_put(wa, 2 * int'(a[1]) + 1, d[15:8]);
        end else begin
            for (int l = 0; l < 4; l++) m_put(wa, l, d[8*l +: 8]);
        end
    endtask

    task automatic chk_io();
        chk("ledr", o_io_ledr, m_ledr);
        chk("ledg", o_io_ledg, m_ledg);
        chk("lcd", o_io_lcd, m_lcd);
        for (int k = 0; k < 8; k++) chk($sformatf("hex%0d", k), {25'd0, o_io_hex[k]}, {25'd0, m_hex[k][6:0]});
    endtask

    // one bus cycle: check pre-edge load data, clock, update model, check IO
    task automatic op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input bit us);
        logic [31:0] exp;
        bit known;
        i_lsu_wren = we; i_lsu_size = sz; i_lsu_addr = a; i_st_data = d; i_lsu_unsigned = us;
        #2;
        exp = m_load(a, sz, us, known);
        if (known) chk($sformatf("ld@%08h/sz%0d", a, sz), o_ld_data, exp);
        @(posedge i_clk);
        if (i_reset) begin
            m_ledr = '0; m_ledg = '0; m_lcd = '0;
            for (int k = 0; k < 8; k++) m_hex[k] = '0;
        end else if (we) begin
            m_store(a, sz, d);
        end
        #1;
        i_lsu_wren = 1'b0;
        chk_io();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0, 1, 2: return 32'($urandom_range(0, 255));
            3: return 32'h1000_0000 | lo;
            4: return 32'h1000_1000 | lo;
            5: return 32'h1000_2000 | lo;
            6: return 32'h1000_3000 | lo;
            7: return 32'h1000_4000 | lo;
            8: return 32'h1001_0000 | lo;
            default: begin
                case ($urandom_range(0, 5))
                    0: return 32'h2000_0000 | lo;
                    1: return 32'h0000_2000 | lo;
                    2: return 32'h1000_0004 | lo;
                    3: return 32'h1000_5000 | lo;
                    4: return 32'h1001_0004 | lo;
                    default: return 32'h9000_1000 | lo;
                endcase
            end
        endcase
    endfunction

    logic [31:0] vals [0:9];

    initial begin
        for (int i = 0; i < 8192; i++) begin m_dmem[i] = '0; m_vld[i] = 1'b0; end
        i_reset = 1'b1; i_lsu_addr = '0; i_st_data = '0; i_lsu_size = 2'b10;
        i_lsu_wren = 1'b0; i_lsu_unsigned = 1'b0; i_io_sw = 32'hDEAD_BEEF;
        m_ledr = '0; m_ledg = '0; m_lcd = '0;
        for (int k = 0; k < 8; k++) m_hex[k] = '0;

        // 1: reset
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        chk("rst_ledr", o_io_ledr, 32'h0);
        chk("rst_ledg", o_io_ledg, 32'h0);
        chk("rst_lcd", o_io_lcd, 32'h0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_hex%0d", k), {25'd0, o_io_hex[k]}, 32'h0);

        // 2: ten distinct words
        for (int i = 0; i < 10; i++) begin
            bit dup;
            do begin
                vals[i] = $urandom;
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (vals[j] == vals[i]) dup = 1'b1;
            end while (dup);
            op(1'b1, 2'b10, 32'(4 * i), vals[i], 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            op(1'b0, 2'b10, 32'(4 * i), 32'h0, 1'b0);
            chk($sformatf("word%0d", i), o_ld_data, vals[i]);
        end

        // 3: sub-word merge
        op(1'b1, 2'b10, 32'h40, 32'h1122_3344, 1'b0);
        op(1'b1, 2'b00, 32'h41, 32'h0000_00AA, 1'b0);
        op(1'b1, 2'b01, 32'h42, 32'h0000_BEEF, 1'b0);
        op(1'b0, 2'b10, 32'h40, 32'h0, 1'b0);
        chk("merge_w", o_ld_data, 32'hBEEF_AA44);
        op(1'b0, 2'b00, 32'h41, 32'h0, 1'b0);
        chk("merge_b", o_ld_data, 32'hFFFF_FFAA);
        op(1'b0, 2'b01, 32'h42, 32'h0, 1'b0);
        chk("merge_h", o_ld_data, 32'hFFFF_BEEF);
        op(1'b0, 2'b00, 32'h41, 32'h0, 1'b1);
        chk("merge_bu", o_ld_data, UNS_EN ? 32'h0000_00AA : 32'hFFFF_FFAA);

        // 4: LEDs
        op(1'b1, 2'b10, 32'h1000_0000, 32'h1234_5678, 1'b0);
        chk("ledr_out", o_io_ledr, 32'h1234_5678);
        op(1'b1, 2'b10, 32'h1000_1000, 32'h0000_00FF, 1'b0);
        chk("ledg_out", o_io_ledg, 32'h0000_00FF);
        op(1'b0, 2'b10, 32'h1000_0000, 32'h0, 1'b0);
        chk("ledr_rd", o_ld_data, 32'h1234_5678);
        op(1'b0, 2'b10, 32'h1000_1000, 32'h0, 1'b0);
        chk("ledg_rd", o_ld_data, 32'h0000_00FF);

        // 5: HEX0-3
        op(1'b1, 2'b10, 32'h1000_2000, 32'h7F06_5B4F, 1'b0);
        chk("hex0", {25'd0, o_io_hex[0]}, 32'h4F);
        chk("hex1", {25'd0, o_io_hex[1]}, 32'h5B);
        chk("hex2", {25'd0, o_io_hex[2]}, 32'h06);
        chk("hex3", {25'd0, o_io_hex[3]}, 32'h7F);
        for (int k = 4; k < 8; k++) chk($sformatf("hex%0d_keep", k), {25'd0, o_io_hex[k]}, 32'h0);
        op(1'b1, 2'b00, 32'h1000_3002, 32'h0000_00C0, 1'b0);
        op(1'b0, 2'b00, 32'h1000_3002, 32'h0, 1'b1);
        chk("hex_rd8", o_ld_data, UNS_EN ? 32'h0000_00C0 : 32'hFFFF_FFC0);

        // 6: switches and unmapped
        op(1'b0, 2'b10, 32'h1001_0000, 32'h0, 1'b0);
        chk("sw_rd", o_ld_data, 32'hDEAD_BEEF);
        op(1'b1, 2'b10, 32'h1001_0000, 32'h5555_5555, 1'b0);
        op(1'b0, 2'b10, 32'h1001_0000, 32'h0, 1'b0);
        chk("sw_rd2", o_ld_data, 32'hDEAD_BEEF);
        op(1'b1, 2'b10, 32'h2000_0000, 32'hCAFE_F00D, 1'b0);
        op(1'b0, 2'b10, 32'h2000_0000, 32'h0, 1'b0);
        chk("unmapped", o_ld_data, 32'h0);

        // reset with a store pending: regs clear, store discarded
        i_reset = 1'b1;
        op(1'b1, 2'b10, 32'h1000_4000, 32'hFFFF_FFFF, 1'b0);
        op(1'b1, 2'b10, 32'h0000_0040, 32'h0BAD_0BAD, 1'b0);
        i_reset = 1'b0;
        op(1'b0, 2'b10, 32'h0000_0040, 32'h0, 1'b0);
        chk("rst_nostore", o_ld_data, 32'hBEEF_AA44);

        // fill low DMEM so every random load is defined
        for (int a = 0; a < 256; a += 4) op(1'b1, 2'b10, 32'(a), $urandom, 1'b0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) i_io_sw = $urandom;
            op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom,
               1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
